// File: rtl/config_stream_loader_pkg.sv
// rtl/config_stream_loader_pkg.sv - shared header layout, target codes and FSM encoding for the config loader
package config_loader_pkg;

  localparam int HDR_TGT_MSB  = 31;
  localparam int HDR_TGT_LSB  = 28;
  localparam int HDR_NURN_MSB = 27;
  localparam int HDR_NURN_LSB = 20;
  localparam int HDR_AXON_MSB = 19;
  localparam int HDR_AXON_LSB = 12;
  localparam int HDR_CNT_MSB  = 11;
  localparam int HDR_CNT_LSB  = 0;
  localparam int TGT_W        = HDR_TGT_MSB - HDR_TGT_LSB + 1;

  localparam logic [TGT_W-1:0] TGT_CONFIG_A      = 4'd0;
  localparam logic [TGT_W-1:0] TGT_CONFIG_B      = 4'd1;
  localparam logic [TGT_W-1:0] TGT_AER           = 4'd2;
  localparam logic [TGT_W-1:0] TGT_AXON_MODE1    = 4'd3;
  localparam logic [TGT_W-1:0] TGT_AXON_MODE2    = 4'd4;
  localparam logic [TGT_W-1:0] TGT_AXON_MODE3    = 4'd5;
  localparam logic [TGT_W-1:0] TGT_AXON_MODE4    = 4'd6;
  localparam logic [TGT_W-1:0] TGT_LRN_WGHT      = 4'd7;
  localparam logic [TGT_W-1:0] TGT_NUM_NURN_AXON = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/config_stream_loader_addr_gen.sv
// rtl/config_stream_loader_addr_gen.sv - write address counter: loads header base, advances per write
module config_addr_gen #(
  parameter int NURN_CNT_BIT_WIDTH = 8,
  parameter int AXON_CNT_BIT_WIDTH = 8
) (
  input  logic                                           clk_i,
  input  logic                                           rst_n_i,
  input  logic                                           load_i,
  input  logic                                           lrn_mode_i,
  input  logic [NURN_CNT_BIT_WIDTH-1:0]                  base_nurn_i,
  input  logic [AXON_CNT_BIT_WIDTH-1:0]                  base_axon_i,
  input  logic                                           incr_i,
  output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] addr_o
);

  logic [NURN_CNT_BIT_WIDTH-1:0] r_nurn;
  logic [AXON_CNT_BIT_WIDTH-1:0] r_axon;
  logic                          r_lrn;

  // Learning weights walk {neuron,axon} as one counter; other targets only step the neuron.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_nurn <= '0;
      r_axon <= '0;
      r_lrn  <= 1'b0;
    end else if (load_i) begin
      r_nurn <= base_nurn_i;
      r_axon <= base_axon_i;
      r_lrn  <= lrn_mode_i;
    end else if (incr_i) begin
      if (r_lrn) begin
        {r_nurn, r_axon} <= {r_nurn, r_axon} + 1'b1;
      end else begin
        r_nurn <= r_nurn + 1'b1;
      end
    end
  end

  assign addr_o = {r_nurn, r_axon};

endmodule

// File: rtl/config_stream_loader.sv
// rtl/config_stream_loader.sv - header-driven stream to config-memory write master
module config_stream_loader
  import config_loader_pkg::*;
#(
  parameter int DSIZE                   = 16,
  parameter int NURN_CNT_BIT_WIDTH      = 8,
  parameter int AXON_CNT_BIT_WIDTH      = 8,
  parameter int CONFIG_PARAMETER_NUMBER = 9,
  parameter int CNT_BIT_WIDTH           = 12
) (
  input  logic                                             clk_i,
  input  logic                                             rst_n_i,
  input  logic [DSIZE*2-1:0]                               in_data_i,
  input  logic                                             in_valid_i,
  output logic                                             in_ready_o,
  input  logic                                             cfg_hold_i,
  output logic [DSIZE*2-1:0]                               cfg_data_o,
  output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] cfg_addr_o,
  output logic [CONFIG_PARAMETER_NUMBER-1:0]               cfg_we_o,
  output logic                                             cfg_ce_o,
  output logic                                             busy_o,
  output logic                                             done_o,
  output logic                                             err_o
);

  localparam int AW = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH;

  state_t                               r_state;
  logic                                 r_rdy_en;
  logic [TGT_W-1:0]                     r_tgt;
  logic [CNT_BIT_WIDTH-1:0]             r_remain;
  logic [DSIZE*2-1:0]                   r_data;
  logic [AW-1:0]                        r_addr;
  logic [CONFIG_PARAMETER_NUMBER-1:0]   r_we;
  logic                                 r_done;
  logic                                 r_err;

  logic                                 w_ready;
  logic                                 w_accept;
  logic                                 w_load;
  logic                                 w_incr;
  logic                                 w_tgt_ok;
  logic                                 w_last;
  logic [TGT_W-1:0]                     w_hdr_tgt;
  logic [CNT_BIT_WIDTH-1:0]             w_hdr_cnt;
  logic [AW-1:0]                        w_addr;

  assign w_hdr_tgt = in_data_i[HDR_TGT_MSB:HDR_TGT_LSB];
  assign w_hdr_cnt = in_data_i[HDR_CNT_MSB:HDR_CNT_LSB];
  assign w_tgt_ok  = {1'b0, w_hdr_tgt} < (TGT_W+1)'(CONFIG_PARAMETER_NUMBER);
  assign w_accept  = in_valid_i & w_ready;
  assign w_load    = (r_state == ST_IDLE) & w_accept;
  assign w_incr    = (r_state == ST_DATA) & w_accept;
  assign w_last    = (r_remain == CNT_BIT_WIDTH'(1));

  // r_rdy_en keeps ready low through reset and the first edge after it.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      ST_IDLE:  w_ready = r_rdy_en & ~cfg_hold_i;
      ST_DATA:  w_ready = ~cfg_hold_i;
      ST_DRAIN: w_ready = 1'b1;
      default:  w_ready = 1'b0;
    endcase
  end

  config_addr_gen #(
    .NURN_CNT_BIT_WIDTH (NURN_CNT_BIT_WIDTH),
    .AXON_CNT_BIT_WIDTH (AXON_CNT_BIT_WIDTH)
  ) u_addr_gen (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .load_i      (w_load),
    .lrn_mode_i  (w_hdr_tgt == TGT_LRN_WGHT),
    .base_nurn_i (in_data_i[HDR_NURN_MSB:HDR_NURN_LSB]),
    .base_axon_i (in_data_i[HDR_AXON_MSB:HDR_AXON_LSB]),
    .incr_i      (w_incr),
    .addr_o      (w_addr)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= ST_IDLE;
      r_rdy_en <= 1'b0;
      r_tgt    <= '0;
      r_remain <= '0;
      r_data   <= '0;
      r_addr   <= '0;
      r_we     <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      r_we     <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_tgt    <= w_hdr_tgt;
            r_remain <= w_hdr_cnt;
            r_err    <= ~w_tgt_ok;
            if (w_hdr_cnt == '0) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= w_tgt_ok ? ST_DATA : ST_DRAIN;
            end
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_data   <= in_data_i;
            r_addr   <= w_addr;
            r_we     <= CONFIG_PARAMETER_NUMBER'(1) << r_tgt;
            r_remain <= r_remain - 1'b1;
            if (w_last) r_state <= ST_DONE;
          end
        end
        ST_DRAIN: begin
          if (w_accept) begin
            r_remain <= r_remain - 1'b1;
            if (w_last) r_state <= ST_DONE;
          end
        end
        default: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o = w_ready;
  assign cfg_data_o = r_data;
  assign cfg_addr_o = r_addr;
  assign cfg_we_o   = r_we;
  assign cfg_ce_o   = |r_we;
  assign busy_o     = (r_state != ST_IDLE);
  assign done_o     = r_done;
  assign err_o      = r_err;

endmodule

// File: tb/tb_config_stream_loader.sv
// tb/tb_config_stream_loader.sv - scoreboard bench for config_stream_loader
module tb_config_stream_loader;

  typedef struct packed {
    logic [8:0]  we;
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        cfg_hold_i;
  logic [31:0] cfg_data_o;
  logic [15:0] cfg_addr_o;
  logic [8:0]  cfg_we_o;
  logic        cfg_ce_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int done_cyc = 0;
  wr_t exp_q[$];
  int  wr_cyc[$];

  config_stream_loader dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .in_data_i  (in_data_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .cfg_hold_i (cfg_hold_i),
    .cfg_data_o (cfg_data_o),
    .cfg_addr_o (cfg_addr_o),
    .cfg_we_o   (cfg_we_o),
    .cfg_ce_o   (cfg_ce_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input int tgt, input logic [15:0] addr, input logic [31:0] data);
    wr_t w;
    w.we   = 9'(1) << tgt;
    w.addr = addr;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Monitor: every write pulse must match the head of the expected queue.
  always @(negedge clk_i) begin
    wr_t e;
    if (cfg_we_o != '0) begin
      wr_cyc.push_back(cyc);
      chk("ce_with_we", cfg_ce_o, 1'b1);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {cfg_we_o, cfg_addr_o}, 64'h0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_we", cfg_we_o, e.we);
        chk("wr_addr", cfg_addr_o, e.addr);
        chk("wr_data", cfg_data_o, e.data);
      end
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err_o) err_cnt++;
  end

  task automatic send(input logic [31:0] w);
    bit acc = 0;
    in_data_i  = w;
    in_valid_i = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk_i);
      acc = in_ready_o;
      @(posedge clk_i);
      #1;
    end
    chk("accept", acc, 1'b1);
    in_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 100 && done_cnt < target; i++) begin
      @(posedge clk_i);
      #1;
    end
    chk("done_count", done_cnt, target);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst_n_i    = 1'b0;
    in_data_i  = '0;
    in_valid_i = 1'b0;
    cfg_hold_i = 1'b0;
    #12;
    chk("rst_ready", in_ready_o, 1'b0);
    chk("rst_outs", {cfg_we_o, cfg_ce_o, busy_o, done_o, err_o}, 64'h0);
    chk("rst_data_addr", {cfg_data_o, cfg_addr_o}, 64'h0);
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    @(posedge clk_i);
    #1 chk("idle_ready", in_ready_o, 1'b1);

    // 1: tgt 0, neuron 0x10, three words back-to-back
    wr_cyc.delete();
    push_wr(0, 16'h1000, 32'hAAAA_0001);
    push_wr(0, 16'h1100, 32'hBBBB_0002);
    push_wr(0, 16'h1200, 32'hCCCC_0003);
    send(32'h0100_0003);
    send(32'hAAAA_0001);
    send(32'hBBBB_0002);
    send(32'hCCCC_0003);
    wait_done(1);
    chk("t1_wr_count", wr_cyc.size(), 3);
    if (wr_cyc.size() == 3) begin
      chk("t1_back_to_back", wr_cyc[2] - wr_cyc[0], 2);
      chk("t1_done_after_last", done_cyc, wr_cyc[2] + 1);
    end
    chk("t1_hold_data", {cfg_data_o, cfg_addr_o}, {32'hCCCC_0003, 16'h1200});

    // 2: learning weights, axon carries into neuron
    push_wr(7, 16'h01FF, 32'h0000_0011);
    push_wr(7, 16'h0200, 32'h0000_0022);
    send(32'h701F_F002);
    send(32'h0000_0011);
    send(32'h0000_0022);
    wait_done(2);

    // 3: neuron wraps, axon fixed
    push_wr(1, 16'hFF33, 32'h1234_5678);
    push_wr(1, 16'h0033, 32'h8765_4321);
    send(32'h1FF3_3002);
    send(32'h1234_5678);
    send(32'h8765_4321);
    wait_done(3);
    chk("t3_no_err", err_cnt, 0);

    // 4: bad target drains with ready high even under hold
    send(32'hC000_0004);
    cfg_hold_i = 1'b1;
    #1 chk("t4_drain_ready", in_ready_o, 1'b1);
    for (int i = 0; i < 4; i++) send(32'hDEAD_0000 + i);
    cfg_hold_i = 1'b0;
    wait_done(4);
    chk("t4_err_pulse", err_cnt, 1);

    // 5: hold mid-packet plus random valid gaps
    for (int i = 0; i < 6; i++) push_wr(3, {8'h20 + 8'(i), 8'h05}, 32'h5000_0000 + i);
    send(32'h3200_5006);
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          int gap;
          send(32'h5000_0000 + i);
          gap = $urandom_range(0, 2);
          repeat (gap) begin
            @(posedge clk_i);
            #1;
          end
        end
      end
      begin
        repeat (2) @(posedge clk_i);
        #1 cfg_hold_i = 1'b1;
        #1 chk("t5_hold_ready", in_ready_o, 1'b0);
        repeat (5) @(posedge clk_i);
        #1 cfg_hold_i = 1'b0;
      end
    join
    wait_done(5);
    send(32'h8000_0000);
    wait_done(6);
    chk("t5_err_total", err_cnt, 1);

    // 6: reset mid-packet after two writes
    push_wr(2, 16'h4000, 32'h6000_0000);
    push_wr(2, 16'h4100, 32'h6000_0001);
    send(32'h2400_0005);
    send(32'h6000_0000);
    send(32'h6000_0001);
    @(negedge clk_i);
    #2 rst_n_i = 1'b0;
    #1;
    chk("t6_rst_outs", {cfg_we_o, cfg_ce_o, busy_o, done_o, err_o, in_ready_o}, 64'h0);
    chk("t6_rst_data_addr", {cfg_data_o, cfg_addr_o}, 64'h0);
    in_data_i  = 32'h6000_0002;
    in_valid_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 in_valid_i = 1'b0;
    rst_n_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    chk("t6_idle", {busy_o, in_ready_o}, 2'b01);
    chk("t6_sb_empty", exp_q.size(), 0);
    chk("t6_done_total", done_cnt, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
